mem_wr_arbiter: RTL and testbench
=================================

# mem_wr_arbiter

Round-robin arbiter that shares one RAM write agent port between `NB_REQ` requesters using valid/ready handshakes, with optional burst locking. It sits in front of one write agent slot of the multi-port RAM and drives the `wren`/`wraddr`/`wrdata` triple consumed by the RAM bank and the memory-map accounter. It registers the selected write, so the RAM sees clean one-cycle-latency outputs and can apply backpressure.

## Interface
- `ADDR_WIDTH`, 8, write address width
- `DATA_WIDTH`, 8, write data width
- `NB_REQ`, 4, number of requesters (2..16)
- `MAX_BURST`, 4, maximum consecutive beats granted to one requester (1 means pure round-robin per beat)
- `aclk`  in  1  clock; all logic is rising-edge
- `aresetn`  in  1  asynchronous active-low reset
- `req_valid`  in  NB_REQ  per-requester write request
- `req_addr`  in  NB_REQ*ADDR_WIDTH  requester i address at `[i*ADDR_WIDTH +: ADDR_WIDTH]`
- `req_data`  in  NB_REQ*DATA_WIDTH  requester i data at `[i*DATA_WIDTH +: DATA_WIDTH]`
- `req_ready`  out  NB_REQ  one-hot or zero; requester i's beat is accepted when `req_valid[i] & req_ready[i]`
- `mem_ready`  in  1  RAM port can take the registered write this cycle
- `wren`  out  1  registered write enable to the RAM write agent
- `wraddr`  out  ADDR_WIDTH  registered write address
- `wrdata`  out  DATA_WIDTH  registered write data
- `grant_id`  out  $clog2(NB_REQ) (min 1)  index of the requester that issued the current `wren` beat

## Operation
- Output stage: a single register holding {wren, wraddr, wrdata, grant_id}.
  - `out_free = !wren | mem_ready`.
  - It loads on a handshake.
  - If there is no handshake and `mem_ready` = 1, `wren` clears. Address and data keep their values.
  - While `wren` = 1 and `mem_ready` = 0, every output holds.
- Arbitration runs only when `out_free` = 1. Otherwise `req_ready` = 0.
- `req_ready` is combinational from `req_valid`, state and `mem_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- A requester holds `req_valid`, `req_addr` and `req_data` stable until its handshake.
- State machine, with registers `rr_ptr` (next priority index), `owner`, and `beat_cnt` (width $clog2(MAX_BURST)+1):
  - **IDLE**: the winner is the first `i` with `req_valid[i]`, scanning `rr_ptr`, `rr_ptr`+1, … mod `NB_REQ`.
    - On a handshake with MAX_BURST = 1: `rr_ptr` ← winner+1 mod `NB_REQ`, stay in IDLE.
    - On a handshake with MAX_BURST > 1: `owner` ← winner, `beat_cnt` ← 1, go to LOCKED.
  - **LOCKED**: only `owner` can be granted.
    - On an owner handshake, `beat_cnt` increments. When it reaches `MAX_BURST`: `rr_ptr` ← owner+1, go to IDLE.
    - If `req_valid[owner]` = 0 while `out_free` = 1: `rr_ptr` ← owner+1, go to IDLE, and arbitrate normally in the same cycle. That handshake follows the IDLE rules.
    - While `out_free` = 0, LOCKED holds unchanged.
- Wrap-around: the priority scan and `rr_ptr` increment modulo `NB_REQ`. This holds for non-power-of-2 `NB_REQ`.
- No requests: `req_ready` = 0 and the state does not change.

## Timing
- Latency: a handshake at edge k makes `wren`, `wraddr`, `wrdata` and `grant_id` valid after edge k. The beat is consumed at the first edge where `mem_ready` = 1.
- Throughput: one beat per cycle when `mem_ready` is held at 1.
- Backpressure: with `mem_ready` = 0 and `wren` = 1, `req_ready` = 0 on the same cycle, so no beat is lost or duplicated.
- Reset (asynchronous assert, synchronous-safe deassert):
  - `wren` = 0, `wraddr` = 0, `wrdata` = 0, `grant_id` = 0.
  - `rr_ptr` = 0, `beat_cnt` = 0, state IDLE.
  - `req_ready` = 0 while `aresetn` = 0.
- Reset mid-burst or mid-stall discards the pending output beat. The first grant after reset favors requester 0.

## Test plan
- **Reset values**: pulse `aresetn` low while `wren` = 1 is stalled → all outputs go to 0 immediately. With all requesters valid after release, first grant goes to requester 0.
- **Round-robin fairness**: MAX_BURST = 1, NB_REQ = 4, all valid continuously, `mem_ready` = 1 → `grant_id` sequence is 0,1,2,3,0,1… with `wren` = 1 every cycle.
- **Burst lock**: MAX_BURST = 4, req 2 and req 3 valid, `rr_ptr` = 2 → four consecutive beats from 2, then beats from 3. If req 2 drops after 2 beats, req 3 is granted in the same cycle.
- **Backpressure**: req 1 writes addr 0x10 / data 0xAA. Hold `mem_ready` = 0 for 3 cycles → outputs stay 0x10 / 0xAA with `wren` = 1 and `req_ready` = 0. Release → one write is consumed and the next request proceeds.
- **Wrap with sparse requests**: NB_REQ = 3, only req 0 valid with `rr_ptr` = 1 → req 0 is granted and `rr_ptr` becomes 1.
- **Idle gap**: no requests for 5 cycles after a write with `mem_ready` = 1 → `wren` = 0 after one cycle, while `wraddr` and `wrdata` hold their last values.

Source files
------------

// File: rtl/mem_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_wr_arbiter_if
// Bundle of the requester-side and RAM-side signals of mem_wr_arbiter.
//
// Handshake semantics (valid/ready, applies to every requester i):
//   A beat moves on a rising edge where req_valid[i] & req_ready[i] = 1.
//   req_valid, req_addr and req_data stay stable until that edge.
//   req_valid never depends on req_ready. req_ready is one-hot or zero.
//   On the RAM side, a registered beat (wren = 1) is consumed on the first
//   edge where mem_ready = 1.
//
// Signals:
//   req_valid  [NB_REQ]             per-requester write request
//   req_addr   [NB_REQ*ADDR_WIDTH]  requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data   [NB_REQ*DATA_WIDTH]  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  [NB_REQ]             grant, one-hot or zero
//   mem_ready                       RAM port can take the registered write
//   wren / wraddr / wrdata          registered write towards the RAM
//   grant_id                        requester that issued the current beat
//
// Modports:
//   slave  : the arbiter side (receives requests, drives the RAM write)
//   master : the environment side (requesters and RAM)
// -----------------------------------------------------------------------------
interface mem_wr_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int NB_REQ     = 4,
   parameter int ID_W       = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
);
   logic [NB_REQ-1:0]            req_valid;
   logic [NB_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NB_REQ*DATA_WIDTH-1:0] req_data;
   logic [NB_REQ-1:0]            req_ready;
   logic                         mem_ready;
   logic                         wren;
   logic [ADDR_WIDTH-1:0]        wraddr;
   logic [DATA_WIDTH-1:0]        wrdata;
   logic [ID_W-1:0]              grant_id;

   modport slave (
      input  req_valid,
      input  req_addr,
      input  req_data,
      input  mem_ready,
      output req_ready,
      output wren,
      output wraddr,
      output wrdata,
      output grant_id
   );

   modport master (
      output req_valid,
      output req_addr,
      output req_data,
      output mem_ready,
      input  req_ready,
      input  wren,
      input  wraddr,
      input  wrdata,
      input  grant_id
   );
endinterface

// File: rtl/mem_wr_arbiter.sv
// -----------------------------------------------------------------------------
// mem_wr_arbiter
// Round-robin arbiter sharing one RAM write agent port between NB_REQ
// requesters, with optional burst locking of up to MAX_BURST consecutive beats.
// The selected write is registered so the RAM sees a clean one-cycle-latency
// {wren, wraddr, wrdata, grant_id} and can stall it with mem_ready.
//
// Ports:
//   aclk        clock, rising edge
//   aresetn     asynchronous active-low reset
//   bus         mem_wr_arbiter_if.slave (requests, grants, RAM write)
//   dbg_state   FSM state: 0 = IDLE, 1 = LOCKED
//   dbg_rr_ptr  current round-robin priority index
// -----------------------------------------------------------------------------
module mem_wr_arbiter #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int NB_REQ      = 4,
   parameter int MAX_BURST   = 4,
   localparam int ID_W       = (NB_REQ > 1) ? $clog2(NB_REQ) : 1,
   localparam int CNT_W      = $clog2(MAX_BURST) + 1
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   mem_wr_arbiter_if.slave      bus,
   output logic                 dbg_state,
   output logic [ID_W-1:0]      dbg_rr_ptr
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]       owner_q, owner_d;
   logic [CNT_W-1:0]      beat_q, beat_d;

   logic                  wren_q;
   logic [ADDR_WIDTH-1:0] wraddr_q;
   logic [DATA_WIDTH-1:0] wrdata_q;
   logic [ID_W-1:0]       grant_q;

   logic                  out_free;
   logic [ID_W-1:0]       scan_start;
   logic [ID_W-1:0]       scan;
   logic                  win_found;
   logic [ID_W-1:0]       win_idx;
   logic                  sel_valid;
   logic [ID_W-1:0]       sel_idx;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [NB_REQ-1:0]     req_ready_c;
   logic                  hs;

   // Modulo-NB_REQ increment; NB_REQ need not be a power of two.
   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] p);
      if (p == ID_W'(NB_REQ - 1)) begin
         return '0;
      end
      return p + ID_W'(1);
   endfunction

   // The output register can accept a new beat when it is empty or being
   // drained this cycle.
   assign out_free = !wren_q || bus.mem_ready;

   // Priority scan. In LOCKED the scan only matters when the owner has
   // dropped its request; the lock is then released and arbitration restarts
   // from owner+1 in the same cycle.
   always_comb begin
      scan_start = (state_q == ST_LOCKED) ? wrap_inc(owner_q) : rr_ptr_q;
      win_found  = 1'b0;
      win_idx    = '0;
      scan       = scan_start;
      for (int k = 0; k < NB_REQ; k++) begin
         if (!win_found && bus.req_valid[scan]) begin
            win_found = 1'b1;
            win_idx   = scan;
         end
         scan = wrap_inc(scan);
      end
   end

   // Next-state and grant selection.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      beat_d    = beat_q;
      sel_valid = 1'b0;
      sel_idx   = owner_q;
      if (out_free) begin
         if (state_q == ST_LOCKED && bus.req_valid[owner_q]) begin
            sel_valid = 1'b1;
            sel_idx   = owner_q;
            beat_d    = beat_q + CNT_W'(1);
            if (beat_q == CNT_W'(MAX_BURST - 1)) begin
               state_d  = ST_IDLE;
               rr_ptr_d = wrap_inc(owner_q);
            end
         end else begin
            // IDLE, or LOCKED with the owner gone: an owner that drops its
            // request releases the lock even when nobody else is waiting.
            state_d  = ST_IDLE;
            rr_ptr_d = scan_start;
            if (win_found) begin
               sel_valid = 1'b1;
               sel_idx   = win_idx;
               if (MAX_BURST == 1) begin
                  rr_ptr_d = wrap_inc(win_idx);
               end else begin
                  state_d = ST_LOCKED;
                  owner_d = win_idx;
                  beat_d  = CNT_W'(1);
               end
            end
         end
      end
   end

   // Grant is one-hot on the selected requester and forced low in reset.
   always_comb begin
      req_ready_c = '0;
      for (int k = 0; k < NB_REQ; k++) begin
         req_ready_c[k] = aresetn && sel_valid && (sel_idx == ID_W'(k));
      end
   end

   // Address/data mux of the granted requester.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int k = 0; k < NB_REQ; k++) begin
         if (sel_idx == ID_W'(k)) begin
            sel_addr = bus.req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // The grant already requires req_valid, so a selection is a handshake.
   assign hs = sel_valid;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         beat_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         beat_q   <= beat_d;
      end
   end

   // Output stage: load on handshake, clear wren when drained without a new
   // beat (address/data/grant keep their last values), hold while stalled.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wren_q   <= 1'b0;
         wraddr_q <= '0;
         wrdata_q <= '0;
         grant_q  <= '0;
      end else if (hs) begin
         wren_q   <= 1'b1;
         wraddr_q <= sel_addr;
         wrdata_q <= sel_data;
         grant_q  <= sel_idx;
      end else if (bus.mem_ready) begin
         wren_q   <= 1'b0;
      end
   end

   assign bus.req_ready = req_ready_c;
   assign bus.wren      = wren_q;
   assign bus.wraddr    = wraddr_q;
   assign bus.wrdata    = wrdata_q;
   assign bus.grant_id  = grant_q;

   assign dbg_state     = (state_q == ST_LOCKED);
   assign dbg_rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_mem_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_wr_arbiter
// Three arbiters driven in lockstep from the same requesters:
//   dut0: NB_REQ=4, MAX_BURST=1   dut1: NB_REQ=4, MAX_BURST=4
//   dut2: NB_REQ=3, MAX_BURST=1   (sees requesters 0..2 only)
// A cycle-level reference model per instance predicts grants and outputs.
// -----------------------------------------------------------------------------
module tb_mem_wr_arbiter;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int NR = 4;
   localparam int ND = 3;
   localparam int NB_OF [ND] = '{4, 4, 3};
   localparam int MB_OF [ND] = '{1, 4, 1};

   // ---------------- clock / reset ----------------
   logic aclk    = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   // ---------------- shared stimulus ----------------
   logic [NR-1:0]    valid     = '0;
   logic [NR*AW-1:0] addr_bus  = '0;
   logic [NR*DW-1:0] data_bus  = '0;
   logic             mem_ready = 1'b1;

   mem_wr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_REQ(4)) if0 ();
   mem_wr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_REQ(4)) if1 ();
   mem_wr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_REQ(3)) if2 ();

   assign if0.req_valid = valid;
   assign if0.req_addr  = addr_bus;
   assign if0.req_data  = data_bus;
   assign if0.mem_ready = mem_ready;
   assign if1.req_valid = valid;
   assign if1.req_addr  = addr_bus;
   assign if1.req_data  = data_bus;
   assign if1.mem_ready = mem_ready;
   assign if2.req_valid = valid[2:0];
   assign if2.req_addr  = addr_bus[3*AW-1:0];
   assign if2.req_data  = data_bus[3*DW-1:0];
   assign if2.mem_ready = mem_ready;

   logic       st0, st1, st2;
   logic [1:0] rr0, rr1, rr2;

   mem_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_REQ(4), .MAX_BURST(1)) dut0 (
      .aclk(aclk), .aresetn(aresetn), .bus(if0), .dbg_state(st0), .dbg_rr_ptr(rr0));
   mem_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_REQ(4), .MAX_BURST(4)) dut1 (
      .aclk(aclk), .aresetn(aresetn), .bus(if1), .dbg_state(st1), .dbg_rr_ptr(rr1));
   mem_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_REQ(3), .MAX_BURST(1)) dut2 (
      .aclk(aclk), .aresetn(aresetn), .bus(if2), .dbg_state(st2), .dbg_rr_ptr(rr2));

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;

   // Sampled DUT outputs
   logic          act_wren  [ND];
   logic [AW-1:0] act_addr  [ND];
   logic [DW-1:0] act_data  [ND];
   int            act_gid   [ND];
   logic [3:0]    act_ready [ND];
   int            act_rr    [ND];
   logic          act_st    [ND];
   logic [3:0]    pre_ready [ND];

   // Reference model state
   int            m_rr     [ND];
   int            m_owner  [ND];
   int            m_beats  [ND];
   bit            m_locked [ND];
   bit            m_wren   [ND];
   logic [AW-1:0] m_addr   [ND];
   logic [DW-1:0] m_data   [ND];
   int            m_gid    [ND];

   // Scoreboard of beats issued by dut1 and not yet consumed by the RAM
   logic [2+AW+DW-1:0] exp_q[$];
   logic [2+AW+DW-1:0] exp_w;

   task automatic sample();
      act_wren[0] = if0.wren; act_addr[0] = if0.wraddr; act_data[0] = if0.wrdata;
      act_gid[0] = int'(if0.grant_id); act_ready[0] = if0.req_ready;
      act_rr[0] = int'(rr0); act_st[0] = st0;
      act_wren[1] = if1.wren; act_addr[1] = if1.wraddr; act_data[1] = if1.wrdata;
      act_gid[1] = int'(if1.grant_id); act_ready[1] = if1.req_ready;
      act_rr[1] = int'(rr1); act_st[1] = st1;
      act_wren[2] = if2.wren; act_addr[2] = if2.wraddr; act_data[2] = if2.wrdata;
      act_gid[2] = int'(if2.grant_id); act_ready[2] = {1'b0, if2.req_ready};
      act_rr[2] = int'(rr2); act_st[2] = st2;
   endtask

   task automatic model_reset();
      for (int d = 0; d < ND; d++) begin
         m_rr[d] = 0; m_owner[d] = 0; m_beats[d] = 0; m_locked[d] = 0;
         m_wren[d] = 0; m_addr[d] = '0; m_data[d] = '0; m_gid[d] = 0;
      end
      exp_q.delete();
   endtask

   // Requester that the arbiter should grant this cycle, or -1.
   function automatic int model_pick(int d);
      int start;
      if (m_wren[d] && !mem_ready) return -1;
      if (m_locked[d] && valid[m_owner[d]]) return m_owner[d];
      start = m_locked[d] ? (m_owner[d] + 1) % NB_OF[d] : m_rr[d];
      for (int k = 0; k < NB_OF[d]; k++) begin
         if (valid[(start + k) % NB_OF[d]]) return (start + k) % NB_OF[d];
      end
      return -1;
   endfunction

   task automatic model_edge(int d, int g);
      bit free;
      free = !m_wren[d] || mem_ready;
      if (free && m_locked[d] && !valid[m_owner[d]]) begin
         m_locked[d] = 0;
         m_rr[d] = (m_owner[d] + 1) % NB_OF[d];
      end
      if (g >= 0) begin
         m_wren[d] = 1;
         m_addr[d] = addr_bus[g*AW +: AW];
         m_data[d] = data_bus[g*DW +: DW];
         m_gid[d]  = g;
         if (d == 1) exp_q.push_back({2'(g), m_addr[d], m_data[d]});
         if (MB_OF[d] == 1) begin
            m_rr[d] = (g + 1) % NB_OF[d];
         end else if (!m_locked[d]) begin
            m_locked[d] = 1; m_owner[d] = g; m_beats[d] = 1;
         end else begin
            m_beats[d]++;
            if (m_beats[d] == MB_OF[d]) begin
               m_locked[d] = 0;
               m_rr[d] = (g + 1) % NB_OF[d];
            end
         end
      end else if (mem_ready) begin
         m_wren[d] = 0;
      end
   endtask

   // ---------------- driver + scoreboard: one clock cycle ----------------
   task automatic drive_cycle(input logic [NR-1:0] v, input logic mr);
      int         g [ND];
      logic [3:0] er;
      valid = v;
      mem_ready = mr;
      #1;
      sample();
      for (int d = 0; d < ND; d++) begin
         g[d] = model_pick(d);
         er = (g[d] >= 0) ? 4'(1 << g[d]) : 4'b0;
         pre_ready[d] = act_ready[d];
         checks++;
         if (act_ready[d] !== er) begin
            errors++;
            $display("FAIL req_ready dut%0d t=%0t got=%b exp=%b", d, $time, act_ready[d], er);
         end
      end
      if (act_wren[1] && mr) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_write t=%0t addr=%h data=%h exp=none", $time, act_addr[1], act_data[1]);
         end else begin
            exp_w = exp_q.pop_front();
            if ({2'(act_gid[1]), act_addr[1], act_data[1]} !== exp_w) begin
               errors++;
               $display("FAIL sb_write t=%0t got=%h exp=%h", $time, {2'(act_gid[1]), act_addr[1], act_data[1]}, exp_w);
            end
         end
      end
      @(posedge aclk);
      for (int d = 0; d < ND; d++) model_edge(d, g[d]);
      @(negedge aclk);
      sample();
      for (int d = 0; d < ND; d++) begin
         checks++;
         if (act_wren[d] !== m_wren[d] || act_addr[d] !== m_addr[d] || act_data[d] !== m_data[d]
             || act_gid[d] !== m_gid[d]) begin
            errors++;
            $display("FAIL outputs dut%0d t=%0t got=%b/%h/%h/%0d exp=%b/%h/%h/%0d", d, $time,
                     act_wren[d], act_addr[d], act_data[d], act_gid[d],
                     m_wren[d], m_addr[d], m_data[d], m_gid[d]);
         end
         checks++;
         if (act_rr[d] !== m_rr[d] || act_st[d] !== m_locked[d]) begin
            errors++;
            $display("FAIL fsm dut%0d t=%0t got=rr%0d/st%b exp=rr%0d/st%b", d, $time,
                     act_rr[d], act_st[d], m_rr[d], m_locked[d]);
         end
      end
   endtask

   task automatic do_reset();
      valid = '0;
      mem_ready = 1'b1;
      aresetn = 1'b0;
      model_reset();
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] dt);
      addr_bus[i*AW +: AW] = a;
      data_bus[i*DW +: DW] = dt;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int i = 0; i < NR; i++) set_req(i, AW'(8'h40 + i), DW'(8'hA0 + i));
      do_reset();
      drive_cycle(4'b1111, 1'b1);
      for (int d = 0; d < ND; d++) begin
         checks++;
         if (act_gid[d] !== 0 || act_wren[d] !== 1'b1) begin
            errors++;
            $display("FAIL first_grant dut%0d got=%0d exp=0", d, act_gid[d]);
         end
      end
      drive_cycle(4'b1111, 1'b0);
      // Stalled beat pending; assert reset mid-cycle.
      #2;
      aresetn = 1'b0;
      #1;
      sample();
      for (int d = 0; d < ND; d++) begin
         checks++;
         if (act_wren[d] !== 1'b0 || act_addr[d] !== '0 || act_data[d] !== '0 || act_gid[d] !== 0
             || act_ready[d] !== 4'b0) begin
            errors++;
            $display("FAIL async_reset dut%0d got=%b/%h/%h/%0d/%b exp=0/00/00/0/0000", d,
                     act_wren[d], act_addr[d], act_data[d], act_gid[d], act_ready[d]);
         end
      end
      model_reset();
      @(negedge aclk);
      aresetn = 1'b1;
      drive_cycle(4'b1111, 1'b1);
      for (int d = 0; d < ND; d++) begin
         checks++;
         if (act_gid[d] !== 0 || act_addr[d] !== 8'h40) begin
            errors++;
            $display("FAIL grant_after_reset dut%0d got=%0d/%h exp=0/40", d, act_gid[d], act_addr[d]);
         end
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive_cycle(4'b1111, 1'b1);
         checks++;
         if (act_gid[0] !== i % 4 || act_wren[0] !== 1'b1) begin
            errors++;
            $display("FAIL rr_seq4 beat%0d got=%0d exp=%0d", i, act_gid[0], i % 4);
         end
         checks++;
         if (act_gid[2] !== i % 3) begin
            errors++;
            $display("FAIL rr_seq3 beat%0d got=%0d exp=%0d", i, act_gid[2], i % 3);
         end
      end
   endtask

   task automatic test_burst_lock();
      do_reset();
      drive_cycle(4'b0010, 1'b1);
      for (int i = 0; i < 8; i++) begin
         drive_cycle(4'b1100, 1'b1);
         if (i == 0) begin
            checks++;
            if (act_rr[1] !== 2) begin
               errors++;
               $display("FAIL burst_rr_ptr got=%0d exp=2", act_rr[1]);
            end
         end
         checks++;
         if (act_gid[1] !== ((i < 4) ? 2 : 3)) begin
            errors++;
            $display("FAIL burst_seq beat%0d got=%0d exp=%0d", i, act_gid[1], (i < 4) ? 2 : 3);
         end
      end
      // Owner drops after two beats: next requester granted in the same cycle.
      do_reset();
      drive_cycle(4'b0010, 1'b1);
      drive_cycle(4'b1100, 1'b1);
      drive_cycle(4'b1100, 1'b1);
      drive_cycle(4'b1000, 1'b1);
      checks++;
      if (pre_ready[1] !== 4'b1000 || act_gid[1] !== 3) begin
         errors++;
         $display("FAIL burst_drop got=%b/%0d exp=1000/3", pre_ready[1], act_gid[1]);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      set_req(1, 8'h10, 8'hAA);
      set_req(0, 8'h20, 8'h55);
      drive_cycle(4'b0010, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive_cycle(4'b0001, 1'b0);
         for (int d = 0; d < ND; d++) begin
            checks++;
            if (pre_ready[d] !== 4'b0 || act_wren[d] !== 1'b1 || act_addr[d] !== 8'h10
                || act_data[d] !== 8'hAA) begin
               errors++;
               $display("FAIL stall dut%0d cyc%0d got=%b/%b/%h/%h exp=0000/1/10/aa", d, i,
                        pre_ready[d], act_wren[d], act_addr[d], act_data[d]);
            end
         end
      end
      drive_cycle(4'b0001, 1'b1);
      checks++;
      if (act_addr[1] !== 8'h20 || act_data[1] !== 8'h55 || act_gid[1] !== 0) begin
         errors++;
         $display("FAIL stall_release got=%h/%h/%0d exp=20/55/0", act_addr[1], act_data[1], act_gid[1]);
      end
   endtask

   task automatic test_wrap_sparse();
      do_reset();
      drive_cycle(4'b0001, 1'b1);
      drive_cycle(4'b0001, 1'b1);
      checks++;
      if (act_gid[2] !== 0 || act_rr[2] !== 1) begin
         errors++;
         $display("FAIL wrap_sparse got=gid%0d/rr%0d exp=gid0/rr1", act_gid[2], act_rr[2]);
      end
      drive_cycle(4'b0100, 1'b1);
      checks++;
      if (act_gid[2] !== 2 || act_rr[2] !== 0) begin
         errors++;
         $display("FAIL wrap_ptr got=gid%0d/rr%0d exp=gid2/rr0", act_gid[2], act_rr[2]);
      end
   endtask

   task automatic test_idle_gap();
      do_reset();
      set_req(2, 8'h33, 8'hC4);
      drive_cycle(4'b0100, 1'b1);
      for (int i = 0; i < 5; i++) begin
         drive_cycle(4'b0000, 1'b1);
         for (int d = 0; d < ND; d++) begin
            checks++;
            if (act_wren[d] !== 1'b0 || act_addr[d] !== 8'h33 || act_data[d] !== 8'hC4) begin
               errors++;
               $display("FAIL idle_gap dut%0d cyc%0d got=%b/%h/%h exp=0/33/c4", d, i,
                        act_wren[d], act_addr[d], act_data[d]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [NR-1:0] hold;
      logic          mr;
      do_reset();
      hold = '0;
      for (int n = 0; n < 600; n++) begin
         if (n == 300) begin
            do_reset();
            hold = '0;
         end
         for (int i = 0; i < NR; i++) begin
            if (!hold[i] && $urandom_range(0, 1) == 1) begin
               hold[i] = 1'b1;
               set_req(i, AW'($urandom), DW'($urandom));
            end
         end
         mr = ($urandom_range(0, 3) != 0);
         drive_cycle(hold, mr);
         hold = hold & ~(pre_ready[1] & hold);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_burst_lock();
      test_backpressure();
      test_wrap_sparse();
      test_idle_gap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
      $finish;
   end
endmodule
